// File: rtl/regfile_pkg.sv
// Shared widths and controller state encoding for the register-file
// access controller and its write buffer.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_CAP    = 2'd1,
        WR_SETUP  = 2'd2,
        WR_COMMIT = 2'd3
    } ctrlState_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Core-side channels: write request, dual-read request, read response.
// master = core (requester), slave = access controller.
interface regfile_access_ctrl_if;
    import regfile_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr1, rd_addr2,
        output rsp_ready,
        input  wr_ready, rd_ready,
        input  rsp_valid, rsp_data1, rsp_data2
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr1, rd_addr2,
        input  rsp_ready,
        output wr_ready, rd_ready,
        output rsp_valid, rsp_data1, rsp_data2
    );

endinterface

// File: rtl/rf_write_buffer.sv
// Write FIFO with count, full/empty, head view and two lookup ports that
// return the youngest buffered value for an address. Sync active-low reset.
module rf_write_buffer
    import regfile_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] pushAddr,
    input  logic [DW-1:0] pushData,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] headAddr,
    output logic [DW-1:0] headData,
    input  logic [AW-1:0] lookAddr1,
    input  logic [AW-1:0] lookAddr2,
    output logic          hit1,
    output logic          hit2,
    output logic [DW-1:0] lookData1,
    output logic [DW-1:0] lookData2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addrMem [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          doPush;
    logic          doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headAddr = addrMem[rdPtr];
    assign headData = dataMem[rdPtr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem[wrPtr] <= pushAddr;
            dataMem[wrPtr] <= pushData;
        end
    end

    // Walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        hit1      = 1'b0;
        hit2      = 1'b0;
        lookData1 = '0;
        lookData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PW'(i);
            if (CW'(i) < count) begin
                if (addrMem[idx] == lookAddr1) begin
                    hit1      = 1'b1;
                    lookData1 = dataMem[idx];
                end
                if (addrMem[idx] == lookAddr2) begin
                    hit2      = 1'b1;
                    lookData2 = dataMem[idx];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences buffered writes onto a mode-driven register file (setup, then
// one-cycle mode pulse) and serves forwarded dual reads on a response channel.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_access_ctrl_if.slave core,
    output logic                 rf_mode,
    output logic [ADDR_W-1:0]    rf_write_address,
    output logic [DATA_W-1:0]    rf_write_value,
    output logic [ADDR_W-1:0]    rf_read_address1,
    output logic [ADDR_W-1:0]    rf_read_address2,
    input  logic [DATA_W-1:0]    rf_read_value1,
    input  logic [DATA_W-1:0]    rf_read_value2,
    output logic                 idle
);

    ctrlState_t        state;
    logic              rspValid;
    logic [DATA_W-1:0] rspData1;
    logic [DATA_W-1:0] rspData2;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic              rdAccept;
    logic              startDrain;

    assign core.wr_ready  = !full;
    assign core.rd_ready  = (state == IDLE) && !full && !rspValid;
    assign core.rsp_valid = rspValid;
    assign core.rsp_data1 = rspData1;
    assign core.rsp_data2 = rspData2;
    assign idle           = (state == IDLE) && empty && !rspValid;

    // Full blocks rd_ready, so a full buffer always drains from IDLE.
    assign rdAccept   = core.rd_valid && core.rd_ready;
    assign startDrain = (state == IDLE) && !rdAccept && !empty;

    rf_write_buffer #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (WBUF_DEPTH)
    ) wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (core.wr_valid),
        .pushAddr  (core.wr_addr),
        .pushData  (core.wr_data),
        .pop       (state == WR_COMMIT),
        .full      (full),
        .empty     (empty),
        .headAddr  (headAddr),
        .headData  (headData),
        .lookAddr1 (rf_read_address1),
        .lookAddr2 (rf_read_address2),
        .hit1      (hit1),
        .hit2      (hit2),
        .lookData1 (fwd1),
        .lookData2 (fwd2)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            rf_mode          <= 1'b0;
            rspValid         <= 1'b0;
            rspData1         <= '0;
            rspData2         <= '0;
            rf_write_address <= '0;
            rf_write_value   <= '0;
            rf_read_address1 <= '0;
            rf_read_address2 <= '0;
        end else begin
            if (rspValid && core.rsp_ready) rspValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rdAccept) begin
                        rf_read_address1 <= core.rd_addr1;
                        rf_read_address2 <= core.rd_addr2;
                        state            <= RD_CAP;
                    end else if (startDrain) begin
                        rf_write_address <= headAddr;
                        rf_write_value   <= headData;
                        state            <= WR_SETUP;
                    end
                end
                RD_CAP: begin
                    rspData1 <= hit1 ? fwd1 : rf_read_value1;
                    rspData2 <= hit2 ? fwd2 : rf_read_value2;
                    rspValid <= 1'b1;
                    state    <= IDLE;
                end
                WR_SETUP: begin
                    rf_mode <= 1'b1;
                    state   <= WR_COMMIT;
                end
                WR_COMMIT: begin
                    rf_mode <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file model, architectural
// shadow reference, directed scenarios and randomized traffic.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic clearRf;
    always #5 clk = ~clk;

    regfile_access_ctrl_if bus();

    logic              rf_mode;
    logic [ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0] rf_write_value;
    logic [ADDR_W-1:0] rf_read_address1;
    logic [ADDR_W-1:0] rf_read_address2;
    logic [DATA_W-1:0] rf_read_value1;
    logic [DATA_W-1:0] rf_read_value2;
    logic              idle;

    regfile_access_ctrl #(.WBUF_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .core             (bus),
        .rf_mode          (rf_mode),
        .rf_write_address (rf_write_address),
        .rf_write_value   (rf_write_value),
        .rf_read_address1 (rf_read_address1),
        .rf_read_address2 (rf_read_address2),
        .rf_read_value1   (rf_read_value1),
        .rf_read_value2   (rf_read_value2),
        .idle             (idle)
    );

    // Register file: level-sensitive write while mode=1, combinational reads.
    logic [DATA_W-1:0] rfMem [32];
    always @(posedge clk) begin
        if (clearRf) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= '0;
        end else if (rf_mode) begin
            rfMem[rf_write_address] <= rf_write_value;
        end
    end
    assign rf_read_value1 = rfMem[rf_read_address1];
    assign rf_read_value2 = rfMem[rf_read_address2];

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wrEnt_t;
    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } rspEnt_t;

    // Architectural view: a write takes effect when accepted.
    logic [DATA_W-1:0] shadow [32];
    wrEnt_t  wrQ[$];
    rspEnt_t expQ[$];

    int nPass = 0;
    int nTotal = 0;
    int cyc = 0;
    int lastRdCyc = -100;
    int lastModeCyc = 0;
    int modeCount = 0;
    bit needSync = 1'b0;
    logic prevMode = 1'b0;
    logic prevStall = 1'b0;
    logic prevRspValid = 1'b0;
    logic [ADDR_W-1:0] prevWa = '0;
    logic [DATA_W-1:0] prevWv = '0;
    logic [DATA_W-1:0] prevD1 = '0;
    logic [DATA_W-1:0] prevD2 = '0;

    task automatic expectEq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        nTotal++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            nPass++;
    endtask

    task automatic evalCycle();
        wrEnt_t  w;
        rspEnt_t r;
        cyc++;
        if (!reset) begin
            wrQ.delete();
            expQ.delete();
            needSync     = 1'b1;
            prevStall    = 1'b0;
            prevRspValid = 1'b0;
        end else begin
            if (needSync) begin
                for (int i = 0; i < 32; i++) shadow[i] = rfMem[i];
                needSync = 1'b0;
            end
            expectEq("wr_ready", bus.wr_ready, wrQ.size() < 4);
            if (wrQ.size() == 4 || bus.rsp_valid)
                expectEq("rd_ready_blocked", bus.rd_ready, 0);
            if (prevStall) begin
                expectEq("rsp_hold_valid", bus.rsp_valid, 1);
                expectEq("rsp_hold_data1", bus.rsp_data1, prevD1);
                expectEq("rsp_hold_data2", bus.rsp_data2, prevD2);
            end
            if (bus.rsp_valid && !prevRspValid)
                expectEq("rsp_latency", cyc, lastRdCyc + 2);
            if (idle)
                expectEq("idle_wbuf_empty", wrQ.size(), 0);
            if (rf_mode) begin
                lastModeCyc = cyc;
                modeCount++;
                expectEq("mode_one_cycle", prevMode, 0);
                expectEq("setup_addr_stable", rf_write_address, prevWa);
                expectEq("setup_value_stable", rf_write_value, prevWv);
                if (wrQ.size() == 0) begin
                    expectEq("commit_without_write", rf_mode, 0);
                end else begin
                    w = wrQ.pop_front();
                    expectEq("commit_addr", rf_write_address, w.a);
                    expectEq("commit_value", rf_write_value, w.d);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (expQ.size() == 0) begin
                    expectEq("rsp_without_read", bus.rsp_valid, 0);
                end else begin
                    r = expQ.pop_front();
                    expectEq("rsp_data1", bus.rsp_data1, r.d1);
                    expectEq("rsp_data2", bus.rsp_data2, r.d2);
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                shadow[bus.wr_addr] = bus.wr_data;
                w.a = bus.wr_addr;
                w.d = bus.wr_data;
                wrQ.push_back(w);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                r.d1 = shadow[bus.rd_addr1];
                r.d2 = shadow[bus.rd_addr2];
                expQ.push_back(r);
                lastRdCyc = cyc;
            end
            prevStall    = bus.rsp_valid && !bus.rsp_ready;
            prevRspValid = bus.rsp_valid;
        end
        prevMode = rf_mode;
        prevWa   = rf_write_address;
        prevWv   = rf_write_value;
        prevD1   = bus.rsp_data1;
        prevD2   = bus.rsp_data2;
    endtask

    task automatic tick();
        #1;
        evalCycle();
        @(negedge clk);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 100 && !idle; n++) tick();
        expectEq("wait_idle", idle, 1);
    endtask

    task automatic doRead(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                          output logic [DATA_W-1:0] d1, output logic [DATA_W-1:0] d2);
        logic acc;
        acc = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr1 = a1;
        bus.rd_addr2 = a2;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = bus.rd_ready;
            tick();
        end
        bus.rd_valid = 1'b0;
        expectEq("read_accept", acc, 1);
        for (int n = 0; n < 50 && !bus.rsp_valid; n++) tick();
        expectEq("read_response", bus.rsp_valid, 1);
        d1 = bus.rsp_data1;
        d2 = bus.rsp_data2;
    endtask

    function automatic logic [ADDR_W-1:0] pickAddr();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : ADDR_W'(r);
    endfunction

    initial begin
        logic [DATA_W-1:0] d1, d2, val;
        int accCyc, saved;
        bit sawFull;

        reset = 1'b0;
        clearRf = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        clearRf = 1'b0;
        reset = 1'b1;
        #1;
        expectEq("reset_rf_mode", rf_mode, 0);
        expectEq("reset_rsp_valid", bus.rsp_valid, 0);
        expectEq("reset_idle", idle, 1);
        expectEq("reset_rsp_data1", bus.rsp_data1, 0);
        expectEq("reset_rsp_data2", bus.rsp_data2, 0);
        expectEq("reset_wr_addr", rf_write_address, 0);
        expectEq("reset_wr_value", rf_write_value, 0);
        expectEq("reset_rd_addr1", rf_read_address1, 0);
        expectEq("reset_wr_ready", bus.wr_ready, 1);

        // Single write, no reads: mode pulse timing.
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234ABCD;
        accCyc = cyc + 1;
        tick();
        bus.wr_valid = 1'b0;
        repeat (8) tick();
        expectEq("t1_commit_delay", lastModeCyc, accCyc + 3);
        expectEq("t1_idle", idle, 1);

        // Write and read on the same edge: the write is forwarded.
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'hDEADBEEF;
        bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd0;
        tick();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        tick();
        expectEq("t2_rsp_valid", bus.rsp_valid, 1);
        expectEq("t2_fwd_data1", bus.rsp_data1, 32'hDEADBEEF);
        expectEq("t2_rf_data2", bus.rsp_data2, 32'h1234ABCD);
        waitIdle();

        // Fill the buffer with writes to addr 2 while reads are pending.
        bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd2; bus.rd_addr2 = 5'd2;
        val = '0;
        sawFull = 1'b0;
        for (int n = 0; n < 40 && !sawFull; n++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = val + 1;
            if (bus.wr_ready) val = val + 1;
            tick();
            if (wrQ.size() == 4) sawFull = 1'b1;
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        expectEq("t3_full_rd_ready", bus.rd_ready, 0);
        expectEq("t3_full_wr_ready", bus.wr_ready, 0);
        doRead(5'd2, 5'd2, d1, d2);
        expectEq("t3_fwd_youngest1", d1, val);
        expectEq("t3_fwd_youngest2", d2, val);
        waitIdle();
        doRead(5'd2, 5'd2, d1, d2);
        expectEq("t3_drained_value", d1, val);
        waitIdle();

        // Response backpressure.
        bus.rsp_ready = 1'b0;
        doRead(5'd1, 5'd2, d1, d2);
        bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd1;
        repeat (5) tick();
        expectEq("t4_held_valid", bus.rsp_valid, 1);
        expectEq("t4_held_data1", bus.rsp_data1, d1);
        expectEq("t4_held_data2", bus.rsp_data2, d2);
        expectEq("t4_rd_blocked", bus.rd_ready, 0);
        bus.rsp_ready = 1'b1;
        tick();
        expectEq("t4_rd_ready_after_release", bus.rd_ready, 1);
        tick();
        bus.rd_valid = 1'b0;
        expectEq("t4_next_accepted", lastRdCyc, cyc);
        waitIdle();

        // Reset in the middle of a commit with three writes buffered.
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = ADDR_W'(5 + k);
            bus.wr_data  = $urandom;
            tick();
        end
        bus.wr_valid = 1'b0;
        for (int n = 0; n < 10 && !rf_mode; n++) tick();
        expectEq("t5_in_commit", rf_mode, 1);
        expectEq("t5_buffered", wrQ.size(), 3);
        saved = modeCount;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expectEq("t5_mode_dropped", rf_mode, 0);
        expectEq("t5_idle", idle, 1);
        repeat (10) tick();
        expectEq("t5_no_pulses", modeCount, saved);

        // Top address on both ports.
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 32'hFFFFFFFF;
        tick();
        bus.wr_valid = 1'b0;
        waitIdle();
        doRead(5'd31, 5'd31, d1, d2);
        expectEq("t6_addr31_port1", d1, 32'hFFFFFFFF);
        expectEq("t6_addr31_port2", d2, 32'hFFFFFFFF);
        waitIdle();

        // Randomized traffic on a small address set to provoke forwarding.
        for (int n = 0; n < 600; n++) begin
            bus.wr_valid  = ($urandom_range(0, 1) == 1);
            bus.wr_addr   = pickAddr();
            bus.wr_data   = $urandom;
            bus.rd_valid  = ($urandom_range(0, 2) == 0);
            bus.rd_addr1  = pickAddr();
            bus.rd_addr2  = pickAddr();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        waitIdle();
        expectEq("final_writes_committed", wrQ.size(), 0);
        expectEq("final_reads_returned", expQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator-side controller for the 32x32 mode-driven register file.
- The register file has level-sensitive writes while mode=1, combinational reads, and two read ports.
- This block accepts write and dual-read requests from a core over valid/ready channels and buffers writes in a small FIFO.
- It sequences writes onto the register file with an address-setup cycle before mode is raised, and returns read data, forwarded from pending writes, on a response channel.

Parameters:
- ADDR_W, 5, register address width (32 entries).
- DATA_W, 32, register data width.
- WBUF_DEPTH, 4, write-buffer entries (power of two).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted when wr_valid&&wr_ready; equals !wbuf_full.
- wr_addr  in  ADDR_W  write register address.
- wr_data  in  DATA_W  write value.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read accept.
- rd_addr1  in  ADDR_W  read address, port 1.
- rd_addr2  in  ADDR_W  read address, port 2.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_data1  out  DATA_W  port-1 result.
- rsp_data2  out  DATA_W  port-2 result.
- rf_mode  out  1  to register file: 0 read, 1 write.
- rf_write_address  out  ADDR_W  to register file.
- rf_write_value  out  DATA_W  to register file.
- rf_read_address1  out  ADDR_W  to register file.
- rf_read_address2  out  ADDR_W  to register file.
- rf_read_value1  in  DATA_W  from register file.
- rf_read_value2  in  DATA_W  from register file.
- idle  out  1  state IDLE && wbuf empty && !rsp_valid.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; wbuf is emptied and its pointers and count cleared.
  - All outputs clear to 0: rf_mode, rsp_valid, rsp_data*, rf_* addresses and values.
  - Reset during WR_COMMIT drops rf_mode to 0 at that edge. Buffered, uncommitted writes are discarded.
- All outputs are registered except wr_ready, rd_ready and idle.
- States: IDLE, RD_CAP, WR_SETUP, WR_COMMIT.
- IDLE priority, evaluated each cycle:
  1. wbuf full -> go to WR_SETUP; rd_ready=0.
  2. Else if rd_valid && !rsp_valid -> rd_ready=1; latch rd_addr1/2 into rf_read_address1/2; go to RD_CAP.
  3. Else if wbuf non-empty -> go to WR_SETUP.
  4. rd_ready=0 in every state other than IDLE.
- RD_CAP (one cycle, rf_mode=0):
  - At the edge, rsp_data1/2 capture rf_read_value1/2, each overridden by the youngest wbuf entry whose address matches.
  - rsp_valid is set; go to IDLE.
  - Latency: accept at edge N, rsp_valid high after edge N+1.
- Response handling:
  - rsp_valid and rsp_data are held stable until rsp_ready.
  - rsp_valid clears on the consuming edge.
  - A new read is accepted only when rsp_valid=0 at the start of the cycle.
- WR_SETUP:
  - rf_write_address/value load the wbuf head; rf_mode stays 0.
  - Next state is WR_COMMIT.
- WR_COMMIT:
  - rf_mode=1 for exactly one cycle, with address/value unchanged.
  - At the edge: pop the head, rf_mode->0, go to IDLE.
  - rf_write_address/value hold their last values afterwards.
- Write buffer:
  - Enqueue on wr_valid&&wr_ready in any state.
  - A simultaneous enqueue and pop is allowed; the count is unchanged.
  - Pointers wrap modulo WBUF_DEPTH; count ranges 0..WBUF_DEPTH.
- Ordering:
  - A write accepted on the same edge as a read accept is older and visible to that read via forwarding.
  - A write accepted during RD_CAP is younger and not visible.
  - The entry popped at a WR_COMMIT edge is already in the register file, so RD_CAP never overlaps a commit.
- Forwarding compares all valid entries. Each port resolves independently, and the same address on both ports returns the same value.
- Reads have priority over drains except when wbuf is full, which guarantees forward progress for writes.

Decomposition:
- Package regfile_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding constants: IDLE=2'd0, RD_CAP=2'd1, WR_SETUP=2'd2, WR_COMMIT=2'd3.
- Sub-module rf_write_buffer:
  - FIFO with count and full/empty.
  - Two parallel address-compare lookup ports (hit + youngest-match data).
- Top level: state machine and response register.

Test Plan:
- Reset, then write addr 0 = 32'h1234ABCD with no reads -> rf_mode low, then high for exactly 1 cycle two cycles after accept. rf_write_address=0 is stable across both cycles; idle returns to 1.
- Write addr 1 = 32'hDEADBEEF and, on the same edge, read (1,0) with the register file returning stale 0 for addr 1 -> rsp_data1=32'hDEADBEEF (forwarded), rsp_data2=32'h1234ABCD.
- Enqueue four writes to addr 2 (values 1,2,3,4) while holding rd_valid=1 -> rd_ready=0 once full. Drains happen in order; a read of addr 2 after drain returns 4. Forwarding before drain also returns 4 (youngest wins).
- Hold rsp_ready=0 for 5 cycles after a response -> rsp_valid and rsp_data stay stable and rd_ready=0. Release -> next read accepted the following cycle.
- Assert reset during WR_COMMIT with 3 entries buffered -> rf_mode=0 next cycle, idle=1, no further rf_mode pulses.
- Read addresses (31,31) after writing 32'hFFFFFFFF to addr 31 and draining -> both rsp_data equal 32'hFFFFFFFF; wbuf pointer wrap is verified after 5+ enqueue/pop cycles.
